// File: rtl/alu_op_sequencer_if.sv
// Bundle of the command, ALU and response signals around alu_op_sequencer.
// Handshake rule for both cmd_* and rsp_*: a transfer happens on a rising clk
// edge where valid and ready are both high; the producer holds valid and its
// payload stable until that edge, and ready never depends on the same-cycle
// valid of the other side.
// The master modport is the sequencer view; the slave modport is the
// environment view (front-end, ALU and response consumer).
interface alu_op_sequencer_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        cmd_use_acc;

    logic [31:0] alu_dat1;
    logic [31:0] alu_dat2;
    logic [3:0]  alu_control;
    logic [31:0] alu_result;
    logic        alu_n;
    logic        alu_c;
    logic        alu_v;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic [3:0]  rsp_flags;
    logic        rsp_err;

    modport master (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        output cmd_ready,
        output alu_dat1, alu_dat2, alu_control,
        input  alu_result, alu_n, alu_c, alu_v,
        output rsp_valid, rsp_result, rsp_flags, rsp_err,
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_use_acc,
        input  cmd_ready,
        input  alu_dat1, alu_dat2, alu_control,
        output alu_result, alu_n, alu_c, alu_v,
        input  rsp_valid, rsp_result, rsp_flags, rsp_err,
        output rsp_ready
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: takes one calculator command, drives the combinational
// ALU from registers, waits SETTLE_CYCLES, captures result and {N,Z,C,V},
// and offers them on the response port.
// Optional build macro ACC_CHAIN_EN adds a result accumulator that can stand
// in for operand A when cmd_use_acc is set.
// fsm_state exposes the FSM encoding (0 IDLE, 1 EXEC, 2 RESP) for debug.
module alu_op_sequencer #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    alu_op_sequencer_if.master bus,
    output logic             busy,
    output logic [CNT_W-1:0] op_count,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Settle counter reload: the capture happens on the edge where it reads 0.
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] OP_LAST     = 4'd5;

    state_t      state;
    logic [3:0]  settle_cnt;

    logic        cap_err;
    logic [31:0] cap_result;
    logic [3:0]  cap_flags;
    logic [31:0] opa_sel;

`ifdef ACC_CHAIN_EN
    logic [31:0] acc;

    // Operand A comes from the accumulator when the command asks for chaining.
    always_comb begin
        opa_sel = bus.cmd_a;
        if (bus.cmd_use_acc) begin
            opa_sel = acc;
        end
    end
`else
    logic unused_use_acc;
    assign unused_use_acc = bus.cmd_use_acc;

    // Without chaining, operand A is always the command operand.
    always_comb begin
        opa_sel = bus.cmd_a;
    end
`endif

    // Capture values: ALU outputs with a local zero flag, overridden for
    // opcodes the ALU does not define.
    always_comb begin
        cap_err    = (bus.alu_control > OP_LAST);
        cap_result = bus.alu_result;
        cap_flags  = {bus.alu_n, (bus.alu_result == 32'd0), bus.alu_c, bus.alu_v};
        if (cap_err) begin
            cap_result = 32'hFFFF_FFFF;
            cap_flags  = 4'b0000;
        end
    end

    assign fsm_state = state;

    // Sequencer FSM with all outputs registered; ALU inputs only change on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            settle_cnt      <= 4'd0;
            bus.cmd_ready   <= 1'b1;
            bus.alu_dat1    <= 32'd0;
            bus.alu_dat2    <= 32'd0;
            bus.alu_control <= 4'd0;
            bus.rsp_valid   <= 1'b0;
            bus.rsp_result  <= 32'd0;
            bus.rsp_flags   <= 4'd0;
            bus.rsp_err     <= 1'b0;
            busy            <= 1'b0;
            op_count        <= '0;
`ifdef ACC_CHAIN_EN
            acc             <= 32'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.alu_dat1    <= opa_sel;
                        bus.alu_dat2    <= bus.cmd_b;
                        bus.alu_control <= bus.cmd_op;
                        settle_cnt      <= SETTLE_LOAD;
                        bus.cmd_ready   <= 1'b0;
                        busy            <= 1'b1;
                        state           <= EXEC;
                    end
                end

                EXEC: begin
                    if (settle_cnt == 4'd0) begin
                        bus.rsp_result <= cap_result;
                        bus.rsp_flags  <= cap_flags;
                        bus.rsp_err    <= cap_err;
                        bus.rsp_valid  <= 1'b1;
`ifdef ACC_CHAIN_EN
                        if (!cap_err) begin
                            acc <= cap_result;
                        end
`endif
                        state          <= RESP;
                    end else begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end

                RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        op_count      <= op_count + 1'b1;
                        bus.cmd_ready <= 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end

                default: begin
                    state         <= IDLE;
                    bus.cmd_ready <= 1'b1;
                    bus.rsp_valid <= 1'b0;
                    busy          <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer: one instance with SETTLE_CYCLES=1 for
// the functional vectors and one with SETTLE_CYCLES=4 for latency and reset
// abort. A small behavioural ALU feeds both instances.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;

    alu_op_sequencer_if bus1();
    alu_op_sequencer_if bus4();

    logic        busy1;
    logic        busy4;
    logic [15:0] cnt1;
    logic [15:0] cnt4;
    logic [1:0]  st1;
    logic [1:0]  st4;

    int vectors;
    int miscompares;
    int exp_cnt1;

    logic        seen_busy;
    logic        seen_ready;
    logic        seen_rv;
    logic [31:0] seen_dat1;
    logic [31:0] seen_dat2;
    logic [3:0]  seen_ctl;

    alu_op_sequencer #(.SETTLE_CYCLES(1), .CNT_W(16)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1),
        .busy      (busy1),
        .op_count  (cnt1),
        .fsm_state (st1)
    );

    alu_op_sequencer #(.SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus4),
        .busy      (busy4),
        .op_count  (cnt4),
        .fsm_state (st4)
    );

    // Behavioural ALU: returns {c, v, result}; sub carry is the borrow out.
    function automatic logic [33:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] ctl);
        logic [32:0] w;
        logic        c;
        logic        v;
        w = 33'd0;
        c = 1'b0;
        v = 1'b0;
        case (ctl)
            4'd0: begin
                w = {1'b0, a} + {1'b0, b};
                c = w[32];
                v = (a[31] == b[31]) && (w[31] != a[31]);
            end
            4'd1: begin
                w = {1'b0, a} - {1'b0, b};
                c = w[32];
                v = (a[31] != b[31]) && (w[31] != a[31]);
            end
            4'd2: w = {1'b0, a * b};
            4'd3: w = {1'b0, a | b};
            4'd4: w = {1'b0, a << b[4:0]};
            4'd5: w = {1'b0, a >> b[4:0]};
            default: w = {1'b0, 32'h1234_5678};
        endcase
        return {c, v, w[31:0]};
    endfunction

    assign {bus1.alu_c, bus1.alu_v, bus1.alu_result} = alu_fn(bus1.alu_dat1, bus1.alu_dat2, bus1.alu_control);
    assign bus1.alu_n = bus1.alu_result[31];
    assign {bus4.alu_c, bus4.alu_v, bus4.alu_result} = alu_fn(bus4.alu_dat1, bus4.alu_dat2, bus4.alu_control);
    assign bus4.alu_n = bus4.alu_result[31];

    // Clock: 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one command into dut1, record its EXEC-cycle view, stop after the
    // capture edge (response visible, handshake pending).
    task automatic issue1(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_acc);
        bus1.cmd_valid   = 1'b1;
        bus1.cmd_op      = op;
        bus1.cmd_a       = a;
        bus1.cmd_b       = b;
        bus1.cmd_use_acc = use_acc;
        tick();
        bus1.cmd_valid   = 1'b0;
        seen_busy  = busy1;
        seen_ready = bus1.cmd_ready;
        seen_rv    = bus1.rsp_valid;
        seen_dat1  = bus1.alu_dat1;
        seen_dat2  = bus1.alu_dat2;
        seen_ctl   = bus1.alu_control;
        tick();
    endtask

    // Complete the pending dut1 response with rsp_ready high.
    task automatic finish1(input string tag);
        tick();
        exp_cnt1++;
        check({tag, "_rv_low"}, 32'(bus1.rsp_valid), 32'd0);
        check({tag, "_count"}, 32'(cnt1), 32'(exp_cnt1));
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_cnt1    = 0;
        rst_n       = 1'b0;
        bus1.cmd_valid = 1'b0; bus1.cmd_op = 4'd0; bus1.cmd_a = 32'd0; bus1.cmd_b = 32'd0;
        bus1.cmd_use_acc = 1'b0; bus1.rsp_ready = 1'b1;
        bus4.cmd_valid = 1'b0; bus4.cmd_op = 4'd0; bus4.cmd_a = 32'd0; bus4.cmd_b = 32'd0;
        bus4.cmd_use_acc = 1'b0; bus4.rsp_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_cmd_ready", 32'(bus1.cmd_ready), 32'd1);
        check("rst_rsp_valid", 32'(bus1.rsp_valid), 32'd0);
        check("rst_busy", 32'(busy1), 32'd0);
        check("rst_count", 32'(cnt1), 32'd0);
        check("rst_dat1", bus1.alu_dat1, 32'd0);
        check("rst_result", bus1.rsp_result, 32'd0);
        check("rst_state", 32'(st1), 32'd0);
        rst_n = 1'b1;
        tick();

        // Add 5 + 7
        issue1(4'd0, 32'd5, 32'd7, 1'b0);
        check("add_exec_busy", 32'(seen_busy), 32'd1);
        check("add_exec_ready", 32'(seen_ready), 32'd0);
        check("add_exec_rv", 32'(seen_rv), 32'd0);
        check("add_exec_ctl", 32'(seen_ctl), 32'd0);
        check("add_exec_dat1", seen_dat1, 32'd5);
        check("add_exec_dat2", seen_dat2, 32'd7);
        check("add_rv", 32'(bus1.rsp_valid), 32'd1);
        check("add_result", bus1.rsp_result, 32'd12);
        check("add_flags", 32'(bus1.rsp_flags), 32'b0000);
        check("add_err", 32'(bus1.rsp_err), 32'd0);
        check("add_resp_ready", 32'(bus1.cmd_ready), 32'd0);
        check("add_count_pre", 32'(cnt1), 32'd0);
        finish1("add");
        check("add_idle_ready", 32'(bus1.cmd_ready), 32'd1);
        check("add_idle_busy", 32'(busy1), 32'd0);
        check("add_idle_hold", bus1.alu_dat1, 32'd5);

        // Sub to negative, then to zero
        issue1(4'd1, 32'd3, 32'd5, 1'b0);
        check("subn_result", bus1.rsp_result, 32'hFFFF_FFFE);
        check("subn_flags", 32'(bus1.rsp_flags), 32'b1010);
        finish1("subn");
        issue1(4'd1, 32'd9, 32'd9, 1'b0);
        check("subz_result", bus1.rsp_result, 32'd0);
        check("subz_flags", 32'(bus1.rsp_flags), 32'b0100);
        finish1("subz");

        // Or and shifts
        issue1(4'd3, 32'h0000_00F0, 32'h0000_000F, 1'b0);
        check("or_result", bus1.rsp_result, 32'h0000_00FF);
        check("or_flags", 32'(bus1.rsp_flags), 32'b0000);
        finish1("or");
        issue1(4'd4, 32'd1, 32'd31, 1'b0);
        check("lsl_result", bus1.rsp_result, 32'h8000_0000);
        check("lsl_flags", 32'(bus1.rsp_flags), 32'b1000);
        finish1("lsl");
        issue1(4'd5, 32'h8000_0000, 32'd31, 1'b0);
        check("lsr_result", bus1.rsp_result, 32'd1);
        check("lsr_flags", 32'(bus1.rsp_flags), 32'b0000);
        finish1("lsr");

        // Backpressure with a second command waiting
        bus1.rsp_ready = 1'b0;
        issue1(4'd1, 32'd3, 32'd5, 1'b0);
        bus1.cmd_valid = 1'b1;
        bus1.cmd_op    = 4'd0;
        bus1.cmd_a     = 32'd1;
        bus1.cmd_b     = 32'd1;
        for (int i = 0; i < 5; i++) begin
            check("bp_rv", 32'(bus1.rsp_valid), 32'd1);
            check("bp_result", bus1.rsp_result, 32'hFFFF_FFFE);
            check("bp_flags", 32'(bus1.rsp_flags), 32'b1010);
            check("bp_cmd_ready", 32'(bus1.cmd_ready), 32'd0);
            check("bp_count", 32'(cnt1), 32'(exp_cnt1));
            tick();
        end
        bus1.rsp_ready = 1'b1;
        finish1("bp");
        check("bp_no_b2b", 32'(busy1), 32'd0);
        check("bp_ready_back", 32'(bus1.cmd_ready), 32'd1);
        tick();
        bus1.cmd_valid = 1'b0;
        check("bp_next_busy", 32'(busy1), 32'd1);
        check("bp_next_dat1", bus1.alu_dat1, 32'd1);
        tick();
        check("bp_next_result", bus1.rsp_result, 32'd2);
        finish1("bp_next");

        // Illegal opcode
        issue1(4'd7, 32'd1, 32'd1, 1'b0);
        check("ill_exec_ctl", 32'(seen_ctl), 32'd7);
        check("ill_result", bus1.rsp_result, 32'hFFFF_FFFF);
        check("ill_flags", 32'(bus1.rsp_flags), 32'b0000);
        check("ill_err", 32'(bus1.rsp_err), 32'd1);
        finish1("ill");

        // Accumulator chaining (use_acc ignored when the feature is absent)
        issue1(4'd0, 32'd10, 32'd5, 1'b0);
        check("acc_seed_result", bus1.rsp_result, 32'd15);
        check("acc_seed_err", 32'(bus1.rsp_err), 32'd0);
        finish1("acc_seed");
        issue1(4'd2, 32'd99, 32'd3, 1'b1);
`ifdef ACC_CHAIN_EN
        check("acc_mul_dat1", seen_dat1, 32'd15);
        check("acc_mul_result", bus1.rsp_result, 32'd45);
`else
        check("acc_mul_dat1", seen_dat1, 32'd99);
        check("acc_mul_result", bus1.rsp_result, 32'd297);
`endif
        finish1("acc_mul");
        issue1(4'd9, 32'd2, 32'd2, 1'b0);
        check("acc_ill_err", 32'(bus1.rsp_err), 32'd1);
        finish1("acc_ill");
        issue1(4'd0, 32'd0, 32'd0, 1'b1);
`ifdef ACC_CHAIN_EN
        check("acc_keep_dat1", seen_dat1, 32'd45);
        check("acc_keep_result", bus1.rsp_result, 32'd45);
`else
        check("acc_keep_dat1", seen_dat1, 32'd0);
        check("acc_keep_result", bus1.rsp_result, 32'd0);
`endif
        finish1("acc_keep");

        // SETTLE_CYCLES=4 latency: mul 6*7
        bus4.cmd_valid = 1'b1;
        bus4.cmd_op    = 4'd2;
        bus4.cmd_a     = 32'd6;
        bus4.cmd_b     = 32'd7;
        tick();
        bus4.cmd_valid = 1'b0;
        check("s4_exec_ctl", 32'(bus4.alu_control), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s4_wait_rv", 32'(bus4.rsp_valid), 32'd0);
        end
        tick();
        check("s4_rv", 32'(bus4.rsp_valid), 32'd1);
        check("s4_result", bus4.rsp_result, 32'd42);
        check("s4_flags", 32'(bus4.rsp_flags), 32'b0000);
        tick();
        check("s4_count", 32'(cnt4), 32'd1);

        // Reset abort mid-EXEC of a mul
        bus4.cmd_valid = 1'b1;
        bus4.cmd_a     = 32'd11;
        bus4.cmd_b     = 32'd13;
        tick();
        bus4.cmd_valid = 1'b0;
        tick();
        check("abort_pre_busy", 32'(busy4), 32'd1);
        rst_n = 1'b0;
        #2;
        check("abort_busy", 32'(busy4), 32'd0);
        check("abort_rv", 32'(bus4.rsp_valid), 32'd0);
        check("abort_cmd_ready", 32'(bus4.cmd_ready), 32'd1);
        check("abort_count", 32'(cnt4), 32'd0);
        check("abort_dat1", bus4.alu_dat1, 32'd0);
        check("abort_dat2", bus4.alu_dat2, 32'd0);
        check("abort_ctl", 32'(bus4.alu_control), 32'd0);
        check("abort_state", 32'(st4), 32'd0);
        check("abort_count1", 32'(cnt1), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("abort_still_idle", 32'(busy4), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
Name: alu_op_sequencer

Overview:
- Command-side initiator for the combinational 32-bit ALU.
- Accepts calculator operations over a valid/ready command port and drives the ALU's dat1/dat2/control inputs from registered values.
- Holds the operands stable for a programmable settle window, then captures the result and flags and presents them on a valid/ready response port.
- Sits between the calculator front-end (keypad/command decoder) and the ALU.

Parameters:
- SETTLE_CYCLES, 1: cycles the ALU inputs are held before capture. Legal range 1..15; covers the multiply path timing.
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clk  in  1  system clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  4  ALU opcode: 0 add, 1 sub, 2 mul, 3 or, 4 lsl, 5 lsr
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_use_acc  in  1  use accumulator as operand A (see Optional Feature)
- alu_dat1  out  32  to ALU dat1
- alu_dat2  out  32  to ALU dat2
- alu_control  out  4  to ALU control
- alu_result  in  32  from ALU result
- alu_n, alu_c, alu_v  in  1 each  from ALU flags
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_result  out  32  captured result
- rsp_flags  out  4  {N,Z,C,V}
- rsp_err  out  1  illegal opcode
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses

Behaviour:
- Reset: already decided — one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0 except cmd_ready = 1. Internal state: FSM = IDLE, settle counter 0, accumulator 0.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready, latch op, A and B into the alu_* registers; go to EXEC; load settle counter = SETTLE_CYCLES-1.
- EXEC:
  - cmd_ready = 0; alu_* outputs held constant.
  - Counter decrements each cycle.
  - On the cycle the counter is 0, capture on that clock edge:
    - rsp_result = alu_result
    - N = alu_n
    - Z = (alu_result == 0), computed locally
    - C = alu_c, V = alu_v
  - Then go to RESP.
- RESP:
  - rsp_valid = 1; rsp_result, rsp_flags and rsp_err stable until rsp_valid & rsp_ready.
  - On handshake: rsp_valid -> 0, op_count += 1 (wraps at 2^CNT_W-1 -> 0), return to IDLE.
- Latency: command accepted on edge T gives rsp_valid high after edge T+SETTLE_CYCLES. With SETTLE_CYCLES=1 and rsp_ready tied high, the minimum command-to-command period is 3 cycles.
- No back-to-back acceptance: cmd_ready is low in EXEC and RESP, including the RESP handshake cycle. cmd_ready returns high the cycle after the response handshake.
- Illegal opcode 6..15:
  - Still sequenced through EXEC (ALU driven as given).
  - Captured values forced to rsp_result = 32'hFFFFFFFF, rsp_flags = 4'b0000, rsp_err = 1.
  - op_count still increments.
- rsp_err = 0 for legal opcodes.
- Operand widths: 32-bit passthrough. Overflow and shift semantics belong to the ALU; the sequencer performs no arithmetic except the Z compare.
- rst_n asserted mid-EXEC or mid-RESP: immediate abort to IDLE. The response is lost, no count, outputs go to reset values.
- The alu_* registers retain their last values in IDLE, so there is no glitching on the ALU inputs.

Optional Feature:
- Macro: ACC_CHAIN_EN.
- Defined:
  - A 32-bit accumulator is loaded with rsp_result at every capture where rsp_err = 0. It is unchanged on error.
  - On command accept with cmd_use_acc = 1, alu_dat1 = accumulator instead of cmd_a.
- Undefined:
  - No accumulator register.
  - cmd_use_acc port still present but ignored; alu_dat1 always = cmd_a.

Test Plan:
- Add, SETTLE_CYCLES=1, rsp_ready=1: cmd op=0, a=5, b=7 accepted at edge T -> alu_control=0 during EXEC; rsp_valid high after T+1 with rsp_result=12, flags=0000, rsp_err=0; op_count=1 after handshake.
- Sub giving negative and zero:
  - op=1, a=3, b=5 -> rsp_result=32'hFFFFFFFE, N=1, Z=0.
  - op=1, a=9, b=9 -> rsp_result=0, flags=0100.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp_result/flags stable, cmd_ready=0 throughout, op_count unchanged; rsp_ready=1 -> one handshake, cmd_ready=1 the next cycle.
- Illegal opcode: op=7, a=1, b=1 -> rsp_result=32'hFFFFFFFF, rsp_err=1, flags=0000, op_count increments.
- Reset abort: assert rst_n low during EXEC of a mul (SETTLE_CYCLES=4) -> next observation: busy=0, rsp_valid=0, cmd_ready=1, op_count=0, alu_* = 0.
- ACC_CHAIN_EN: op=0, a=10, b=5 (result 15); then op=2, use_acc=1, a=99, b=3 -> alu_dat1=15, rsp_result=45. Then illegal op -> accumulator stays 45.
